// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/D memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic       {REQ_IF, REQ_D}           req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around mem_port_arbiter.
// master = core pipeline plus memory, slave = the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_guard.sv
// Fixed D-over-IF priority with a saturating IF starvation counter.
// MEM_ARB_STATS_EN adds a 'forced' output flagging starvation-forced IF wins.
module arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_req,
    input  logic    d_req,
    input  logic    arb_en,
    output req_id_t winner
`ifdef MEM_ARB_STATS_EN
    ,
    output logic    forced
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign winner   = (d_req && !force_if) ? REQ_D : REQ_IF;

`ifdef MEM_ARB_STATS_EN
    // A forced win only counts when D was actually contending.
    assign forced = force_if && d_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb_en && if_req) begin
            if (winner == REQ_IF) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (D).
// Optional MEM_ARB_STATS_EN adds 16-bit saturating grant/starvation counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       if_cnt,
    output logic [15:0]       d_cnt,
    output logic [15:0]       starve_evt
`endif
);

    localparam int CNT_W = 3;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be within 1..4");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_id_t          win, win_nxt, winner;
    logic             we, we_nxt;
    logic             any_req;

    logic              if_gnt_nxt, d_gnt_nxt, if_rvalid_nxt, d_rvalid_nxt;
    logic              mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

    assign any_req  = bus.if_req || bus.d_req;
    assign bus.busy = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    logic forced;
`endif

    arb_starve_guard #(.STARVE_MAX(STARVE_MAX)) u_guard (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .arb_en (state == IDLE),
        .winner (winner)
`ifdef MEM_ARB_STATS_EN
        ,
        .forced (forced)
`endif
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        win_nxt       = win;
        we_nxt        = we;
        if_gnt_nxt    = 1'b0;
        d_gnt_nxt     = 1'b0;
        if_rvalid_nxt = 1'b0;
        d_rvalid_nxt  = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        if_rdata_nxt  = bus.if_rdata;
        d_rdata_nxt   = bus.d_rdata;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt  = ISSUE;
                    cnt_nxt    = CNT_W'(RD_LAT);
                    win_nxt    = winner;
                    mem_en_nxt = 1'b1;
                    if (winner == REQ_D) begin
                        d_gnt_nxt     = 1'b1;
                        we_nxt        = bus.d_we;
                        mem_we_nxt    = bus.d_we;
                        mem_addr_nxt  = bus.d_addr;
                        mem_wdata_nxt = bus.d_we ? bus.d_wdata : '0;
                    end else begin
                        if_gnt_nxt   = 1'b1;
                        we_nxt       = 1'b0;
                        mem_addr_nxt = bus.if_addr;
                    end
                end
            end
            ISSUE: begin
                // Writes land in memory at the end of ISSUE and complete next cycle.
                if (we) begin
                    state_nxt    = RESP;
                    d_rvalid_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    if (win == REQ_D) begin
                        d_rvalid_nxt = 1'b1;
                        d_rdata_nxt  = bus.mem_rdata;
                    end else begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = bus.mem_rdata;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            win           <= REQ_IF;
            we            <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            win           <= win_nxt;
            we            <= we_nxt;
            bus.if_gnt    <= if_gnt_nxt;
            bus.d_gnt     <= d_gnt_nxt;
            bus.if_rvalid <= if_rvalid_nxt;
            bus.d_rvalid  <= d_rvalid_nxt;
            bus.if_rdata  <= if_rdata_nxt;
            bus.d_rdata   <= d_rdata_nxt;
            bus.mem_en    <= mem_en_nxt;
            bus.mem_we    <= mem_we_nxt;
            bus.mem_addr  <= mem_addr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_cnt     <= '0;
            d_cnt      <= '0;
            starve_evt <= '0;
        end else if (state == IDLE && any_req) begin
            if (winner == REQ_IF && if_cnt != 16'hFFFF) if_cnt <= if_cnt + 1'b1;
            if (winner == REQ_D && d_cnt != 16'hFFFF)   d_cnt  <= d_cnt + 1'b1;
            if (forced && starve_evt != 16'hFFFF)       starve_evt <= starve_evt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
// Stats checks run only when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(24)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(24)) bus3 ();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] if_cnt1, d_cnt1, starve1, if_cnt3, d_cnt3, starve3;
`endif

    mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_cnt     (if_cnt1),
        .d_cnt      (d_cnt1),
        .starve_evt (starve1)
`endif
    );

    mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus3)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_cnt     (if_cnt3),
        .d_cnt      (d_cnt3),
        .starve_evt (starve3)
`endif
    );

    // Memory model: data is valid for exactly one cycle, RD_LAT edges after mem_en.
    logic [23:0] mem [256];
    logic        p1_v = 1'b0;
    logic [23:0] p1_d;
    logic [2:0]  p3_v = 3'b000;
    logic [23:0] p3_d [3];

    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_we) mem[bus1.mem_addr] <= bus1.mem_wdata;
        p1_v <= bus1.mem_en && !bus1.mem_we;
        p1_d <= mem[bus1.mem_addr];
        p3_v <= {p3_v[1:0], bus3.mem_en && !bus3.mem_we};
        p3_d[0] <= mem[bus3.mem_addr];
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end

    assign bus1.mem_rdata = p1_v    ? p1_d    : 24'hBAD0BA;
    assign bus3.mem_rdata = p3_v[2] ? p3_d[2] : 24'hBAD0BA;

    // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}
    logic [6:0] fl1, fl3;
    assign fl1 = {bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid,
                  bus1.mem_en, bus1.mem_we, bus1.busy};
    assign fl3 = {bus3.if_gnt, bus3.d_gnt, bus3.if_rvalid, bus3.d_rvalid,
                  bus3.mem_en, bus3.mem_we, bus3.busy};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.d_req  = 1'b0; bus1.d_we    = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0;
        bus3.d_req  = 1'b0; bus3.d_we    = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        int          n_gnt;
        int          overlap;
        int          acc;
        logic [5:0]  rv_vec, en_vec, busy_vec;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h05] = 24'h00ABCD;
        clear_inputs();

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_flags1", 32'(fl1), 32'h0);
        check("rst_flags3", 32'(fl3), 32'h0);
        check("rst_addr", 32'(bus1.mem_addr), 32'h0);
        check("rst_if_rdata", 32'(bus1.if_rdata), 32'h0);
        check("rst_d_rdata", 32'(bus1.d_rdata), 32'h0);
        rst_n = 1'b1;
        tick();

        // IF-only read, RD_LAT=1
        bus1.if_req = 1'b1; bus1.if_addr = 8'h05;
        tick();
        check("t1_issue_flags", 32'(fl1), 32'(7'b1000101));
        check("t1_issue_addr", 32'(bus1.mem_addr), 32'h05);
        bus1.if_req = 1'b0;
        tick();
        check("t1_wait_flags", 32'(fl1), 32'(7'b0000001));
        check("t1_wait_addr", 32'(bus1.mem_addr), 32'h0);
        tick();
        check("t1_resp_flags", 32'(fl1), 32'(7'b0010001));
        check("t1_rdata", 32'(bus1.if_rdata), 32'h00ABCD);
        tick();
        check("t1_idle_flags", 32'(fl1), 32'h0);
        check("t1_rdata_hold", 32'(bus1.if_rdata), 32'h00ABCD);

        // D write then D read
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 8'h10; bus1.d_wdata = 24'h123456;
        tick();
        check("t2w_issue_flags", 32'(fl1), 32'(7'b0100111));
        check("t2w_addr", 32'(bus1.mem_addr), 32'h10);
        check("t2w_wdata", 32'(bus1.mem_wdata), 32'h123456);
        bus1.d_req = 1'b0;
        tick();
        check("t2w_resp_flags", 32'(fl1), 32'(7'b0001001));
        check("t2w_rdata_unchanged", 32'(bus1.d_rdata), 32'h0);
        tick();
        check("t2w_idle_flags", 32'(fl1), 32'h0);
        bus1.d_req = 1'b1; bus1.d_we = 1'b0;
        tick();
        check("t2r_issue_flags", 32'(fl1), 32'(7'b0100101));
        bus1.d_req = 1'b0;
        tick();
        check("t2r_wait_flags", 32'(fl1), 32'(7'b0000001));
        tick();
        check("t2r_resp_flags", 32'(fl1), 32'(7'b0001001));
        check("t2r_rdata", 32'(bus1.d_rdata), 32'h123456);
        tick();

        // Both requesting continuously: D,D,D,D,IF,D,D,D,D,IF
        bus1.if_req = 1'b1; bus1.if_addr = 8'h05;
        bus1.d_req  = 1'b1; bus1.d_we    = 1'b0; bus1.d_addr = 8'h10;
        seq = '0; n_gnt = 0; overlap = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if ((bus1.if_gnt && bus1.d_gnt) || (bus1.if_rvalid && bus1.d_rvalid)) overlap++;
            if ((bus1.if_gnt || bus1.d_gnt) && n_gnt < 16) begin
                seq[n_gnt] = bus1.if_gnt;
                n_gnt++;
            end
        end
        clear_inputs();
        tick();
        tick();
        check("t3_grant_count", 32'(n_gnt), 32'd10);
        check("t3_grant_order", 32'(seq), 32'(16'b0000_0010_0001_0000));
        check("t3_overlap", 32'(overlap), 32'd0);
        check("t3_if_rdata", 32'(bus1.if_rdata), 32'h00ABCD);
        check("t3_d_rdata", 32'(bus1.d_rdata), 32'h123456);

        // D request withdrawn before any IDLE edge sees it
        bus1.if_req = 1'b1; bus1.if_addr = 8'h05;
        tick();
        bus1.if_req = 1'b0;
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 8'h20; bus1.d_wdata = 24'hFFFFFF;
        tick();
        bus1.d_req = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus1.d_gnt || bus1.mem_en) acc++;
        end
        check("t4_no_d_side_effect", 32'(acc), 32'd0);
        check("t4_mem_untouched", 32'(mem[8'h20]), 32'h0);

        // Reset during WAIT, then a fresh IF read
        bus1.if_req = 1'b1; bus1.if_addr = 8'h05;
        tick();
        bus1.if_req = 1'b0;
        tick();
        check("t5_in_wait", 32'(fl1), 32'(7'b0000001));
        rst_n = 1'b0;
        tick();
        check("t5_rst_flags", 32'(fl1), 32'h0);
        check("t5_rst_rdata", 32'(bus1.if_rdata), 32'h0);
        rst_n = 1'b1;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus1.if_rvalid || bus1.d_rvalid || bus1.busy) acc++;
        end
        check("t5_no_late_rvalid", 32'(acc), 32'd0);
        check("t5_rdata_still_zero", 32'(bus1.if_rdata), 32'h0);
        bus1.if_req = 1'b1; bus1.if_addr = 8'h10;
        tick();
        check("t5_fresh_gnt", 32'(fl1), 32'(7'b1000101));
        bus1.if_req = 1'b0;
        tick();
        tick();
        check("t5_fresh_resp", 32'(fl1), 32'(7'b0010001));
        check("t5_fresh_rdata", 32'(bus1.if_rdata), 32'h123456);
        tick();

        // RD_LAT=3 read: three WAIT cycles, rvalid in cycle E+5
        bus3.if_req = 1'b1; bus3.if_addr = 8'h05;
        rv_vec = '0; en_vec = '0; busy_vec = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            bus3.if_req = 1'b0;
            rv_vec[k]   = bus3.if_rvalid;
            en_vec[k]   = bus3.mem_en;
            busy_vec[k] = bus3.busy;
        end
        check("t6_rvalid_timing", 32'(rv_vec), 32'(6'b010000));
        check("t6_mem_en_timing", 32'(en_vec), 32'(6'b000001));
        check("t6_busy_timing", 32'(busy_vec), 32'(6'b011111));
        check("t6_rdata", 32'(bus3.if_rdata), 32'h00ABCD);

`ifdef MEM_ARB_STATS_EN
        // Counters: 4 D + 1 forced IF under contention, then 4 IF alone
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_cnt_reset", 32'(if_cnt1) + 32'(d_cnt1) + 32'(starve1), 32'd0);
        bus1.if_req = 1'b1; bus1.if_addr = 8'h05;
        bus1.d_req  = 1'b1; bus1.d_we    = 1'b0; bus1.d_addr = 8'h10;
        for (int c = 0; c < 20; c++) tick();
        bus1.d_req = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        clear_inputs();
        tick();
        tick();
        check("t7_if_cnt", 32'(if_cnt1), 32'd5);
        check("t7_d_cnt", 32'(d_cnt1), 32'd4);
        check("t7_starve_evt", 32'(starve1), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 24-bit data/instruction memory between the CPU's instruction-fetch unit (IF) and the load/store unit (D).
- Sits between the core pipeline and the memory inside top.
- Arbitrates requests and sequences each memory access through a fixed read latency.
- Returns read data, or a write completion, to the winning requester.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 24, memory data width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle grant pulse to fetch.
- if_rdata  out  DATA_W  fetched word; holds its last value.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle grant pulse to data.
- d_rdata  out  DATA_W  load data; holds its last value.
- d_rvalid  out  1  one-cycle pulse; read data valid or write complete.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst_n is synchronous and active-low. While rst_n=0 at an edge, all outputs are 0, the FSM goes to IDLE, and the starve counter is cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is sampled at an edge, that edge latches the winner's command, moves to ISSUE, and sets cnt=RD_LAT.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Winner's gnt=1, mem_en=1, and mem_we/mem_addr/mem_wdata driven from the latched registers.
  - Read: next state WAIT.
  - Write: next state RESP; the write completes in memory at the end of ISSUE.
- WAIT:
  - cnt decrements each cycle.
  - When cnt reaches 0, that edge captures mem_rdata into the winner's rdata register and moves to RESP.
  - Only RD_LAT=1 → exactly 1 cycle in WAIT.
- RESP (1 cycle):
  - Winner's rvalid=1. For a write, d_rdata is unchanged.
  - Next state IDLE. A request may already be present; it is sampled at the following IDLE edge.
- Latency and throughput:
  - Read: req sampled at edge E → gnt in cycle E+1 → rvalid in cycle E+2+RD_LAT.
  - Write: rvalid in cycle E+2.
  - Read throughput is one access per RD_LAT+3 cycles.
- Arbitration (evaluated only in IDLE):
  - D beats IF, unless starve_cnt==STARVE_MAX; then IF wins.
  - starve_cnt increments (saturating) when IF is requesting and loses. It clears when IF is granted.
- Requester rules:
  - Hold req/addr/we/wdata stable until gnt.
  - Dropping req before gnt withdraws the request with no side effects.
  - req held after gnt is ignored until RESP completes, then it is treated as a new request.
- Outputs:
  - Everything except busy is registered.
  - mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
  - Only one of if_gnt/d_gnt is ever high in a cycle; same for if_rvalid/d_rvalid.
- Reset mid-operation: the outstanding access is abandoned, no rvalid is issued, and late mem_rdata is ignored.
- RD_LAT outside 1..4 is a configuration error: elaboration-time assertion.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs if_cnt, d_cnt and starve_evt, each 16 bits and saturating at 0xFFFF.
  - if_cnt counts IF grants; d_cnt counts D grants; starve_evt counts forced IF grants.
  - All three are cleared by reset.
- Undefined: these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - requester-id typedef {REQ_IF, REQ_D};
  - default width constants (ADDR_W=8, DATA_W=24).
- Sub-module arb_starve_guard: starve counter plus winner select. Inputs are if_req, d_req and an arbitrate enable; outputs the winner id; includes the clear/increment logic.

Test Plan:
- IF-only read, RD_LAT=1, mem[0x05]=0x00ABCD, if_req at edge 0 → if_gnt in cycle 1, mem_addr=0x05 in cycle 1, if_rvalid in cycle 3 with if_rdata=0x00ABCD, busy cycles 1–3.
- D write then D read, addr 0x10, wdata 0x123456:
  - write: d_gnt cycle 1, mem_we=1, d_rvalid cycle 2;
  - read: returns 0x123456 with d_rvalid 3 cycles after its request is sampled.
- IF and D requesting continuously, STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF,…; never both gnts high in one cycle.
- RD_LAT=3 read → exactly 3 WAIT cycles; rvalid in cycle E+5.
- rst_n=0 during WAIT → all outputs 0 at the next edge, no rvalid afterwards; a fresh IF read after reset completes normally.
- MEM_ARB_STATS_EN defined, 5 IF and 3 D grants → if_cnt=5, d_cnt=3; starve_evt matches the number of forced IF wins.
